// File: rtl/gate_vector_checker.sv
// Stimulus/check stage for two-input gates: walks {a,b} through 00..11, samples the gate output
// at the end of each hold window and reports per-vector failures, an error count and a verdict.
module gate_vector_checker #(
  parameter int unsigned HOLD_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] HcLast = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [1:0]    vec_q, vec_d;
  logic [CW-1:0] hc_q, hc_d;
  logic          a_q, a_d, b_q, b_d;
  logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [2:0]    err_q, err_d;
  logic [3:0]    fail_q, fail_d;
  logic          expected;
  logic          mismatch;

  always_comb begin
    expected = 1'b0;
    unique case (op_q)
      3'd0:    expected = vec_q[1] & vec_q[0];
      3'd1:    expected = vec_q[1] | vec_q[0];
      3'd2:    expected = ~(vec_q[1] & vec_q[0]);
      3'd3:    expected = ~(vec_q[1] | vec_q[0]);
      3'd4:    expected = vec_q[1] ^ vec_q[0];
      3'd5:    expected = ~(vec_q[1] ^ vec_q[0]);
      default: expected = 1'b0;
    endcase
  end

  assign mismatch = (y != expected);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    vec_d   = vec_q;
    hc_d    = hc_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (op <= 3'd5) begin
            op_d    = op;
            pass_d  = 1'b0;
            err_d   = 3'd0;
            fail_d  = 4'b0000;
            vec_d   = 2'd0;
            hc_d    = '0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            busy_d  = 1'b1;
            state_d = StRun;
          end else begin
            // Illegal op: report a full failure without driving any vectors.
            pass_d  = 1'b0;
            err_d   = 3'd0;
            fail_d  = 4'b1111;
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (hc_q == HcLast) begin
          if (mismatch) begin
            fail_d[vec_q] = 1'b1;
            err_d         = err_q + 3'd1;
          end
          hc_d = '0;
          if (vec_q == 2'd3) begin
            busy_d  = 1'b0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            vec_d   = 2'd0;
            done_d  = 1'b1;
            pass_d  = (err_q == 3'd0) && !mismatch;
            state_d = StDone;
          end else begin
            vec_d = vec_q + 2'd1;
            {a_d, b_d} = vec_q + 2'd1;
          end
        end else begin
          hc_d = hc_q + CW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= 3'd0;
      vec_q   <= 2'd0;
      hc_q    <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vec_q   <= vec_d;
      hc_q    <= hc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule
